// File: rtl/pattern_tx.sv
// Serial frame transmitter: shifts len payload bits MSB-first, optional even parity (TX_PARITY_EN), then GAP_CYCLES idle.
// Latency: first bit on data one cycle after the load_valid/load_ready handshake; out counts completed frames mod 8.
// Backpressure: load_ready is high only in IDLE, so requests wait until the previous frame and its gap have finished.
module pattern_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic [3:0] load_len,
    input  logic       abort,
    output logic       load_ready,
    output logic       data,
    output logic       data_valid,
    output logic       busy,
    output logic [2:0] out
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef TX_PARITY_EN
        PAR   = 2'd2,
`endif
        GAP   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [3:0] gap_q,   gap_d;
    logic       data_q,  data_d;
    logic       vld_q,   vld_d;
    logic       rdy_q,   rdy_d;
    logic [2:0] out_q,   out_d;
`ifdef TX_PARITY_EN
    logic       parity_q, parity_d;
    logic [7:0] len_mask;
`endif

    logic [3:0] eff_len;
    logic [7:0] aligned;

    // Zero and out-of-range lengths both mean a full byte.
    assign eff_len = (load_len == 4'd0 || load_len > 4'd8) ? 4'd8 : load_len;
    // Left-justify the payload so bit 7 is always the next bit to send.
    assign aligned = load_data << (4'd8 - eff_len);
`ifdef TX_PARITY_EN
    assign len_mask = 8'hFF >> (4'd8 - eff_len);
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        data_d   = 1'b0;
        vld_d    = 1'b0;
        rdy_d    = 1'b0;
        out_d    = out_q;
`ifdef TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (load_valid && rdy_q && !abort) begin
                    state_d  = SHIFT;
                    data_d   = aligned[7];
                    vld_d    = 1'b1;
                    shift_d  = {aligned[6:0], 1'b0};
                    cnt_d    = 3'(eff_len - 4'd1);
                    rdy_d    = 1'b0;
`ifdef TX_PARITY_EN
                    parity_d = ^(load_data & len_mask);
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else if (cnt_q != 3'd0) begin
                    data_d  = shift_q[7];
                    vld_d   = 1'b1;
                    shift_d = {shift_q[6:0], 1'b0};
                    cnt_d   = cnt_q - 3'd1;
                end else begin
`ifdef TX_PARITY_EN
                    state_d = PAR;
                    data_d  = parity_q;
                    vld_d   = 1'b1;
`else
                    state_d = GAP;
                    gap_d   = GAP_LAST;
                    out_d   = out_q + 3'd1;
`endif
                end
            end
`ifdef TX_PARITY_EN
            PAR: begin
                if (abort) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LAST;
                    out_d   = out_q + 3'd1;
                end
            end
`endif
            GAP: begin
                if (abort || gap_q == 4'd0) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= 8'd0;
            cnt_q    <= 3'd0;
            gap_q    <= 4'd0;
            data_q   <= 1'b0;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b0;
            out_q    <= 3'd0;
`ifdef TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            rdy_q    <= rdy_d;
            out_q    <= out_d;
`ifdef TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign load_ready = rdy_q;
    assign data       = data_q;
    assign data_valid = vld_q;
    assign busy       = (state_q != IDLE);
    assign out        = out_q;

endmodule
